stack_engine: RTL

Parametrised LIFO stack with integrated storage, command handshake and error reporting. It is the next-generation stack for the 8-Queen solver and general backtracking datapaths. It generalises the earlier push/pop controller to configurable width and depth, and adds a replace (pop+push) op, a popped-data output, a synchronous clear and a sticky error flag. It sits between the search FSM and the board-state registers.

---
 rtl/stack_pkg.sv | 18 +
 rtl/stack_mem.sv | 42 ++++
 rtl/stack_engine.sv | 122 ++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack engine: command opcodes and controller states.
package stack_pkg;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_PUSH    = 2'b01;
    localparam logic [1:0] OP_POP     = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUSH      = 3'd1,
        ST_POP       = 3'd2,
        ST_REPLACE   = 3'd3,
        ST_OVERFLOW  = 3'd4,
        ST_UNDERFLOW = 3'd5
    } state_t;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, two asynchronous read ports, no reset.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Each entry owns its register so addresses wider than the array need no slicing.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (we && (waddr == AW'(gi))) begin
                    entry_reg <= wdata;
                end
            end
            assign mem[gi] = entry_reg;
        end
    endgenerate

    // Out-of-range addresses (e.g. count-1 when empty) read as zero.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) rdata_a = mem[i];
            if (raddr_b == AW'(i)) rdata_b = mem[i];
        end
    end

endmodule

// File: rtl/stack_engine.sv
// LIFO stack controller: command handshake, two-cycle op FSM, count tracking and error flags.
module stack_engine
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] wr_data,
    output logic             done,
    output logic [WIDTH-1:0] pop_data,
    output logic [WIDTH-1:0] top_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic             err_sticky
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_m1;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] pop_data_reg;
    logic             err_reg;
    logic             accept;
    logic             is_pop_like;
    logic             mem_we;
    logic [CNT_W-1:0] mem_waddr;
    logic [WIDTH-1:0] rd_top;
    logic [WIDTH-1:0] rd_pop;

    assign count_m1    = count_reg - ONE_C;
    assign full        = (count_reg == DEPTH_C);
    assign empty       = (count_reg == '0);
    assign count       = count_reg;
    assign top_data    = empty ? '0 : rd_top;
    assign pop_data    = pop_data_reg;
    assign err_sticky  = err_reg;
    assign cmd_ready   = (state_reg == ST_IDLE);

    // clear outranks any command presented in the same cycle
    assign accept      = cmd_ready && cmd_valid && (cmd_op != OP_NOP) && !clear;
    assign is_pop_like = (cmd_op == OP_POP) || (cmd_op == OP_REPLACE);

    // Pulses are suppressed while clear aborts the in-flight op.
    assign done      = !clear && ((state_reg == ST_PUSH) || (state_reg == ST_POP) ||
                                  (state_reg == ST_REPLACE));
    assign overflow  = !clear && (state_reg == ST_OVERFLOW);
    assign underflow = !clear && (state_reg == ST_UNDERFLOW);

    always_comb begin
        state_next = ST_IDLE;
        if (accept) begin
            case (cmd_op)
                OP_PUSH:    state_next = full  ? ST_OVERFLOW  : ST_PUSH;
                OP_POP:     state_next = empty ? ST_UNDERFLOW : ST_POP;
                OP_REPLACE: state_next = empty ? ST_UNDERFLOW : ST_REPLACE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    assign mem_we    = !reset && !clear &&
                       ((state_reg == ST_PUSH) || (state_reg == ST_REPLACE));
    assign mem_waddr = (state_reg == ST_PUSH) ? count_reg : count_m1;

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (CNT_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (data_reg),
        .raddr_a (count_m1),
        .rdata_a (rd_top),
        .raddr_b (count_m1),
        .rdata_b (rd_pop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            err_reg      <= 1'b0;
            pop_data_reg <= '0;
            data_reg     <= '0;
        end else if (clear) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                data_reg <= wr_data;
            end
            if (accept && is_pop_like && !empty) begin
                pop_data_reg <= rd_pop;
            end
            case (state_reg)
                ST_PUSH:      count_reg <= count_reg + ONE_C;
                ST_POP:       count_reg <= count_m1;
                ST_OVERFLOW,
                ST_UNDERFLOW: err_reg   <= 1'b1;
                default:      ;
            endcase
        end
    end

endmodule
